fifo_pkt_reader: RTL and testbench



---
 rtl/fifo_pkt_pkg.sv | 22 ++
 rtl/fifo_pkt_reader.sv | 162 ++++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkt_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkt_pkg
// Shared definitions for the FIFO packet reader:
//   - state_t         : reader FSM states (CSUM is only entered when the
//                       PKT_CHECKSUM_EN macro is defined)
//   - LEN_LSB/LEN_MSB : bit position of the payload-length field in a header
//   - DEFAULT_MAX_LEN : largest legal payload length in words
// -----------------------------------------------------------------------------
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CSUM    = 2'd2
  } state_t;

  localparam int LEN_LSB         = 0;
  localparam int LEN_MSB         = 15;
  localparam int LEN_FIELD_W     = LEN_MSB - LEN_LSB + 1;
  localparam int DEFAULT_MAX_LEN = 512;

endpackage

// File: rtl/fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// fifo_pkt_reader
// Read-side consumer for a first-word-fall-through FIFO. Pops a header word,
// checks its length field, then forwards that many payload words as a
// valid/ready stream framed with sop/eop. Header words are never forwarded.
//
// Optional feature (macro PKT_CHECKSUM_EN): each packet is followed by a
// trailer word equal to the XOR of its payload words. The trailer is consumed,
// compared, and a mismatch raises a one-cycle err_csum pulse.
//
// Ports:
//   clk            read-domain clock (same as FIFO rclk)
//   res_n          asynchronous active-low reset
//   fifo_d         FIFO head word, valid while fifo_empty=0
//   fifo_empty     FIFO empty flag
//   fifo_shift_out pop request (combinational, never set while empty)
//   out_data       payload word
//   out_valid      out_data/out_sop/out_eop valid
//   out_ready      sink accepts on out_valid & out_ready
//   out_sop        first payload word of a packet
//   out_eop        last payload word of a packet
//   pkt_cnt        completed packets, wraps
//   err_len        one-cycle pulse when a header length is rejected
//   err_csum       (PKT_CHECKSUM_EN only) one-cycle pulse on trailer mismatch
// -----------------------------------------------------------------------------
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int DSIZE   = 32,
  parameter int LEN_W   = LEN_FIELD_W,
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [DSIZE-1:0] fifo_d,
  input  logic             fifo_empty,
  output logic             fifo_shift_out,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err_len
`ifdef PKT_CHECKSUM_EN
  ,
  output logic             err_csum
`endif
);

  state_t           r_state;
  logic [LEN_W-1:0] r_remain;
  logic             r_first;
`ifdef PKT_CHECKSUM_EN
  logic [DSIZE-1:0] r_xor;
`endif

  logic             w_pop;
  logic [LEN_W-1:0] w_len;
  logic             w_len_ok;
  logic             w_last;

  assign w_len    = fifo_d[LEN_W-1:0];
  assign w_len_ok = (w_len != '0) && (32'(w_len) <= 32'(MAX_LEN));
  assign w_last   = (r_remain == LEN_W'(1));

  // Pop decision. In PAYLOAD a word may only be taken when the output
  // register is empty or being drained this cycle, which gives full
  // throughput without a skid buffer.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      IDLE:    w_pop = !fifo_empty;
      PAYLOAD: w_pop = !fifo_empty && (!out_valid || out_ready);
      default: w_pop = !fifo_empty;
    endcase
  end

  // Gated by reset so no word is lost while the block is held in reset.
  assign fifo_shift_out = w_pop & res_n;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state   <= IDLE;
      r_remain  <= '0;
      r_first   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      pkt_cnt   <= '0;
      err_len   <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      r_xor     <= '0;
      err_csum  <= 1'b0;
`endif
    end else begin
      err_len <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      err_csum <= 1'b0;
`endif
      // Drain the output register once accepted; a PAYLOAD pop below
      // overrides this with the next word.
      if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_len_ok) begin
              r_remain <= w_len;
              r_first  <= 1'b1;
              r_state  <= PAYLOAD;
`ifdef PKT_CHECKSUM_EN
              r_xor    <= '0;
`endif
            end else begin
              err_len <= 1'b1;
            end
          end
        end

        PAYLOAD: begin
          if (w_pop) begin
            out_data  <= fifo_d;
            out_valid <= 1'b1;
            out_sop   <= r_first;
            out_eop   <= w_last;
            r_first   <= 1'b0;
            r_remain  <= r_remain - LEN_W'(1);
`ifdef PKT_CHECKSUM_EN
            r_xor     <= r_xor ^ fifo_d;
            if (w_last) begin
              r_state <= CSUM;
            end
`else
            if (w_last) begin
              pkt_cnt <= pkt_cnt + CNT_W'(1);
              r_state <= IDLE;
            end
`endif
          end
        end

`ifdef PKT_CHECKSUM_EN
        CSUM: begin
          if (w_pop) begin
            err_csum <= (fifo_d != r_xor);
            pkt_cnt  <= pkt_cnt + CNT_W'(1);
            r_state  <= IDLE;
          end
        end
`endif

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pkt_reader
// Bench for fifo_pkt_reader. A queue acts as the FWFT FIFO; inputs change on
// the falling edge and outputs are sampled 1 ns later. Expected words, framing,
// error pulses and packet counts come from hand-written vector tables.
// Build with +define+PKT_CHECKSUM_EN to exercise the trailer check as well.
// -----------------------------------------------------------------------------
module tb_fifo_pkt_reader;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] fifo_d;
  logic        fifo_empty;
  logic        fifo_shift_out;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] pkt_cnt;
  logic        err_len;
`ifdef PKT_CHECKSUM_EN
  logic        err_csum;
`endif

  fifo_pkt_reader #(
    .DSIZE  (32),
    .LEN_W  (16),
    .MAX_LEN(512),
    .CNT_W  (16)
  ) dut (
    .clk           (clk),
    .res_n         (res_n),
    .fifo_d        (fifo_d),
    .fifo_empty    (fifo_empty),
    .fifo_shift_out(fifo_shift_out),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .pkt_cnt       (pkt_cnt),
    .err_len       (err_len)
`ifdef PKT_CHECKSUM_EN
    ,
    .err_csum      (err_csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hdr;
    int          n_push;
    logic [31:0] base;
    int          exp_words;
    int          exp_err;
    int          exp_pkt;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  logic [31:0] fq[$];
  logic [31:0] cap_d[$];
  logic        cap_sop[$];
  logic        cap_eop[$];
  int          cap_cyc[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  int   csum_cnt = 0;
  int   exp_pkt_total = 0;
  logic stall = 1'b0;
  logic ready_val = 1'b1;
  logic last_pop = 1'b0;
  logic prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_sop = 1'b0;
  logic prev_eop = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: present FIFO head and ready on the falling edge, sample 1 ns later.
  task automatic step();
    @(negedge clk);
    fifo_empty = (fq.size() == 0) || stall;
    fifo_d     = (fq.size() != 0) ? fq[0] : 32'h0;
    out_ready  = ready_val;
    #1;
    cyc++;
    chk("pop_while_empty", {63'd0, fifo_shift_out & fifo_empty}, 64'd0);
    last_pop = fifo_shift_out;
    if (fifo_shift_out && !fifo_empty) void'(fq.pop_front());
    if (err_len) err_cnt++;
`ifdef PKT_CHECKSUM_EN
    if (err_csum) csum_cnt++;
`endif
    if (prev_hold && res_n) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_data", {32'd0, out_data}, {32'd0, prev_data});
      chk("hold_frame", {62'd0, out_sop, out_eop}, {62'd0, prev_sop, prev_eop});
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_sop  = out_sop;
    prev_eop  = out_eop;
    if (out_valid && out_ready) begin
      cap_d.push_back(out_data);
      cap_sop.push_back(out_sop);
      cap_eop.push_back(out_eop);
      cap_cyc.push_back(cyc);
    end
  endtask

  task automatic push_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base);
    logic [31:0] x;
    x = '0;
    fq.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + i);
      x = x ^ (base + i);
    end
`ifdef PKT_CHECKSUM_EN
    if (n > 0) fq.push_back(x);
`endif
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_sop.delete();
    cap_eop.delete();
    cap_cyc.delete();
  endtask

  // Step until the FIFO is drained and the output register empty, then two
  // more cycles so trailing error pulses are observed.
  task automatic run_idle(input string tag);
    int n;
    n = 0;
    while (n < 2000) begin
      step();
      n++;
      if (fq.size() == 0 && !out_valid) break;
    end
    chk($sformatf("%s_timeout", tag), {63'd0, n >= 2000}, 64'd0);
    step();
    step();
  endtask

  // Pops n captured words and checks data base+i with sop on the first and
  // eop on the last.
  task automatic check_words(input string tag, input logic [31:0] base, input int n);
    chk($sformatf("%s_count", tag), {63'd0, cap_d.size() >= n}, 64'd1);
    for (int i = 0; i < n && cap_d.size() > 0; i++) begin
      chk($sformatf("%s_data%0d", tag, i), {32'd0, cap_d[0]}, {32'd0, base + i});
      chk($sformatf("%s_sop%0d", tag, i), {63'd0, cap_sop[0]}, {63'd0, i == 0});
      chk($sformatf("%s_eop%0d", tag, i), {63'd0, cap_eop[0]}, {63'd0, i == n - 1});
      void'(cap_d.pop_front());
      void'(cap_sop.pop_front());
      void'(cap_eop.pop_front());
      void'(cap_cyc.pop_front());
    end
  endtask

  initial begin
    int start;
    int ta_cyc;

    //            hdr            push base       words err pkt
    vecs[0] = '{32'h0000_0003,   3, 32'h0000_00A1, 3,   0,  1};
    vecs[1] = '{32'h0000_0001,   1, 32'h0000_0055, 1,   0,  1};
    vecs[2] = '{32'h0000_0000,   0, 32'h0,         0,   1,  0};
    vecs[3] = '{32'h0000_0258,   0, 32'h0,         0,   1,  0};  // 600
    vecs[4] = '{32'h0000_0002,   2, 32'h0000_00B1, 2,   0,  1};
    vecs[5] = '{32'hABCD_0002,   2, 32'h0000_00C0, 2,   0,  1};  // upper bits ignored
    vecs[6] = '{32'h0000_FFFF,   0, 32'h0,         0,   1,  0};
    vecs[7] = '{32'h0000_0201,   0, 32'h0,         0,   1,  0};  // 513
    vecs[8] = '{32'h0000_0200, 512, 32'h0000_1000, 512, 0,  1};  // 512

    // Reset state
    res_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_d = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_frame", {62'd0, out_sop, out_eop}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
    chk("rst_err_len", {63'd0, err_len}, 64'd0);
    chk("rst_pop", {63'd0, fifo_shift_out}, 64'd0);
    res_n = 1'b1;
    step();

    // Table-driven packets, sink always ready
    for (int v = 0; v < NV; v++) begin
      err_cnt = 0;
      clear_caps();
      start = cyc;
      push_pkt(vecs[v].hdr, vecs[v].n_push, vecs[v].base);
      run_idle($sformatf("v%0d", v));
      exp_pkt_total += vecs[v].exp_pkt;
      chk($sformatf("v%0d_err_len", v), 64'(err_cnt), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_pkt_cnt", v), {48'd0, pkt_cnt}, 64'(exp_pkt_total));
      if (vecs[v].exp_words > 0 && cap_cyc.size() > 0) begin
        chk($sformatf("v%0d_latency", v), 64'(cap_cyc[0] - start), 64'd3);
        chk($sformatf("v%0d_contig", v), 64'(cap_cyc[cap_cyc.size()-1] - cap_cyc[0]),
            64'(vecs[v].exp_words - 1));
      end
      check_words($sformatf("v%0d", v), vecs[v].base, vecs[v].exp_words);
      chk($sformatf("v%0d_extra", v), 64'(cap_d.size()), 64'd0);
    end

    // Backpressure: sink stalls 5 cycles once the first word is presented
    clear_caps();
    push_pkt(32'd4, 4, 32'h0000_00F0);
    step();
    step();
    ready_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_nopop%0d", i), {63'd0, last_pop}, 64'd0);
      chk($sformatf("bp_data%0d", i), {32'd0, out_data}, 64'h0F0);
      chk($sformatf("bp_valid%0d", i), {63'd0, out_valid}, 64'd1);
    end
    ready_val = 1'b1;
    run_idle("bp");
    exp_pkt_total++;
    check_words("bp", 32'h0000_00F0, 4);
    chk("bp_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt_total));

    // FIFO runs empty for 3 cycles mid-packet
    clear_caps();
    push_pkt(32'd3, 3, 32'h0000_0070);
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_nopop%0d", i), {63'd0, last_pop}, 64'd0);
      if (i == 1) chk("stall_valid_drop", {63'd0, out_valid}, 64'd0);
    end
    stall = 1'b0;
    run_idle("stall");
    exp_pkt_total++;
    check_words("stall", 32'h0000_0070, 3);
    chk("stall_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt_total));

    // Back-to-back packets: header popped right after the eop pop
    clear_caps();
    start = cyc;
    push_pkt(32'd2, 2, 32'h0000_0090);
    push_pkt(32'd1, 1, 32'h0000_00A0);
    run_idle("ta");
    exp_pkt_total += 2;
    ta_cyc = (cap_cyc.size() >= 3) ? cap_cyc[2] - start : -1;
`ifdef PKT_CHECKSUM_EN
    chk("ta_turnaround", 64'(ta_cyc), 64'd7);
`else
    chk("ta_turnaround", 64'(ta_cyc), 64'd6);
`endif
    check_words("ta_a", 32'h0000_0090, 2);
    check_words("ta_b", 32'h0000_00A0, 1);
    chk("ta_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt_total));

`ifdef PKT_CHECKSUM_EN
    // Checksum trailer: good then bad
    clear_caps();
    csum_cnt = 0;
    fq.push_back(32'd3); fq.push_back(32'd1); fq.push_back(32'd2);
    fq.push_back(32'd4); fq.push_back(32'd7);
    run_idle("cs_ok");
    exp_pkt_total++;
    chk("cs_ok_err", 64'(csum_cnt), 64'd0);
    chk("cs_ok_words", 64'(cap_d.size()), 64'd3);
    chk("cs_ok_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt_total));
    clear_caps();
    fq.push_back(32'd3); fq.push_back(32'd1); fq.push_back(32'd2);
    fq.push_back(32'd4); fq.push_back(32'd6);
    run_idle("cs_bad");
    exp_pkt_total++;
    chk("cs_bad_err", 64'(csum_cnt), 64'd1);
    chk("cs_bad_words", 64'(cap_d.size()), 64'd3);
    if (cap_d.size() == 3) chk("cs_bad_last", {32'd0, cap_d[2]}, 64'd4);
    chk("cs_bad_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt_total));
`endif

    // Reset mid-packet: outputs clear immediately, partial packet discarded
    clear_caps();
    push_pkt(32'd3, 3, 32'h0000_00D0);
    repeat (3) step();
    chk("mid_valid_before", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_frame", {62'd0, out_sop, out_eop}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
    chk("mid_rst_pop", {63'd0, fifo_shift_out}, 64'd0);
    fq.delete();
    clear_caps();
    prev_hold = 1'b0;
    exp_pkt_total = 0;
    repeat (2) step();
    res_n = 1'b1;
    step();
    push_pkt(32'd2, 2, 32'h0000_00E0);
    run_idle("post_rst");
    exp_pkt_total++;
    check_words("post_rst", 32'h0000_00E0, 2);
    chk("post_rst_pkt_cnt", {48'd0, pkt_cnt}, 64'(exp_pkt_total));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
